// File: rtl/p2_tdm_mux.sv
// ----------------------------------------------------------------------------
// p2_tdm_mux
//
// Purpose:
//   A 4-to-1 time-division multiplexer with a single-entry registered output.
//   Four producer lanes each offer a word through a valid/ready handshake.
//   One granted lane per cycle is loaded into the output register. The output
//   register is drained by a single downstream consumer through out_valid and
//   out_ready. out_sel travels with every word so that a downstream 1-to-4
//   demux can route it back to the lane it came from.
//
// Configuration macro:
//   P2_TDM_RR_EN  defined   -> round-robin arbitration. A 2-bit pointer
//                              remembers the last granted lane. The search
//                              starts at the lane after it.
//                 undefined -> fixed priority, lane 0 highest and lane 3
//                              lowest. No pointer state is built.
//
// Parameters:
//   DW         data width of every lane and of the output word
//
// Ports:
//   clk        input   1     rising-edge clock for all state
//   rst_n      input   1     asynchronous active-low reset
//   in_valid   input   4     per-lane request, bit k = lane k presents data
//   in_data0   input   DW    lane 0 payload
//   in_data1   input   DW    lane 1 payload
//   in_data2   input   DW    lane 2 payload
//   in_data3   input   DW    lane 3 payload
//   in_ready   output  4     per-lane accept, one-hot or zero
//   out_valid  output  1     output register holds a word
//   out_data   output  DW    payload of the held word
//   out_sel    output  2     lane index of the held word
//   out_ready  input   1     downstream accept
// ----------------------------------------------------------------------------
module p2_tdm_mux #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [3:0]    in_valid,
    input  logic [DW-1:0] in_data0,
    input  logic [DW-1:0] in_data1,
    input  logic [DW-1:0] in_data2,
    input  logic [DW-1:0] in_data3,
    output logic [3:0]    in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic [1:0]    out_sel,
    input  logic          out_ready
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic [1:0]    out_sel_q, out_sel_d;

    logic          ld;
    logic          any_valid;
    logic [1:0]    grant_idx;
    logic [3:0]    grant;
    logic          xfer;
    logic [DW-1:0] sel_data;

`ifdef P2_TDM_RR_EN
    logic [1:0]    last_q, last_d;
`endif

    // The output register can take a new word when it is empty. It can also
    // take one when the held word leaves in this same cycle. This is what
    // allows one word per cycle with no bubble.
    assign ld = (state_q == EMPTY) | out_ready;

    // Arbitration. It looks only at in_valid and, in the round-robin build,
    // at the pointer. It does not look at ld. This keeps the only
    // combinational path from out_ready going to in_ready.
`ifdef P2_TDM_RR_EN
    // Search last+1, last+2, last+3, last. The 2-bit sum wraps 3 back to 0.
    // The loop runs from the farthest candidate to the nearest, so the
    // nearest valid lane is the one left in grant_idx at the end.
    always_comb begin
        logic [1:0] cand;
        any_valid = 1'b0;
        grant_idx = 2'd0;
        cand      = 2'd0;
        for (int i = 4; i >= 1; i--) begin
            cand = last_q + 2'(i);
            if (in_valid[cand]) begin
                any_valid = 1'b1;
                grant_idx = cand;
            end
        end
    end
`else
    // Fixed priority: the lowest-numbered valid lane wins.
    always_comb begin
        any_valid = |in_valid;
        grant_idx = 2'd0;
        if (in_valid[0]) begin
            grant_idx = 2'd0;
        end else if (in_valid[1]) begin
            grant_idx = 2'd1;
        end else if (in_valid[2]) begin
            grant_idx = 2'd2;
        end else if (in_valid[3]) begin
            grant_idx = 2'd3;
        end
    end
`endif

    assign grant = any_valid ? (4'b0001 << grant_idx) : 4'b0000;

    // in_ready is also gated by rst_n. While reset is held the state is EMPTY,
    // so ld is 1. Without this gate a valid lane would see a spurious accept.
    assign in_ready = (grant & {4{ld}}) & {4{rst_n}};

    assign xfer = |(in_valid & in_ready);

    // Route the payload of the granted lane.
    always_comb begin
        sel_data = in_data0;
        case (grant_idx)
            2'd0:    sel_data = in_data0;
            2'd1:    sel_data = in_data1;
            2'd2:    sel_data = in_data2;
            2'd3:    sel_data = in_data3;
            default: sel_data = in_data0;
        endcase
    end

    // Next-state logic. A transfer always leaves the block FULL: it either
    // fills an empty register or replaces a word that is leaving. With no
    // transfer, a FULL register empties only when the consumer accepts.
    // out_data and out_sel keep their last values when the block goes EMPTY.
    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        out_sel_d  = out_sel_q;
        case (state_q)
            EMPTY: begin
                if (xfer) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (out_ready && !xfer) begin
                    state_d = EMPTY;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
        if (xfer) begin
            out_data_d = sel_data;
            out_sel_d  = grant_idx;
        end
    end

`ifdef P2_TDM_RR_EN
    // The pointer moves only when a word is actually taken. A lane that is
    // granted but not loaded does not lose its turn.
    always_comb begin
        last_d = last_q;
        if (xfer) begin
            last_d = grant_idx;
        end
    end

    // The reset value 3 makes lane 0 the first lane searched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 2'd3;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    // Output register and FSM state. Reset discards any held word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            out_data_q <= '0;
            out_sel_q  <= 2'd0;
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            out_sel_q  <= out_sel_d;
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_p2_tdm_mux.sv
// ----------------------------------------------------------------------------
// tb_p2_tdm_mux
//
// Directed testbench for p2_tdm_mux with DW = 8. It works for both builds:
// expectations that differ between round-robin and fixed priority are
// selected with P2_TDM_RR_EN.
// ----------------------------------------------------------------------------
module tb_p2_tdm_mux;

    localparam int DW = 8;

    logic          clk;
    logic          rst_n;
    logic [3:0]    in_valid;
    logic [DW-1:0] in_data0;
    logic [DW-1:0] in_data1;
    logic [DW-1:0] in_data2;
    logic [DW-1:0] in_data3;
    logic [3:0]    in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [1:0]    out_sel;
    logic          out_ready;

    int testsRun;
    int testsFailed;

    p2_tdm_mux #(.DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data0  (in_data0),
        .in_data1  (in_data1),
        .in_data2  (in_data2),
        .in_data3  (in_data3),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every comparison. Report each mismatch on one line.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Drive every input at once.
    task automatic applyStimulus(input logic [3:0] valid, input logic rdy,
                                 input logic [7:0] d0, input logic [7:0] d1,
                                 input logic [7:0] d2, input logic [7:0] d3);
        in_valid  = valid;
        out_ready = rdy;
        in_data0  = d0;
        in_data1  = d1;
        in_data2  = d2;
        in_data3  = d3;
    endtask

    // Step one clock. Return 1 ns after the rising edge, so the bench samples
    // away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse reset low between edges. Then return to the post-edge sampling
    // point.
    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst_n       = 1'b1;
        applyStimulus(4'b1111, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00);
        #2;
        rst_n = 1'b0;
        #1;

        // While reset is held low, all lanes are requesting.
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_out_data", {24'd0, out_data}, 32'h00);
        checkOutput("rst_out_sel", {30'd0, out_sel}, 32'd0);
        checkOutput("rst_in_ready", {28'd0, in_ready}, 32'h0);
        tick();
        checkOutput("rst_hold_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_hold_in_ready", {28'd0, in_ready}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(4'b0000, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00);
        #1;
        checkOutput("idle_in_ready", {28'd0, in_ready}, 32'h0);

        // Single word from lane 0, with one cycle of latency.
        applyStimulus(4'b0001, 1'b1, 8'hA5, 8'h00, 8'h00, 8'h00);
        #1;
        checkOutput("l0_in_ready", {28'd0, in_ready}, 32'h1);
        tick();
        checkOutput("l0_out_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("l0_out_data", {24'd0, out_data}, 32'hA5);
        checkOutput("l0_out_sel", {30'd0, out_sel}, 32'd0);

        // The word drains with no replacement. The register keeps its data.
        applyStimulus(4'b0000, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00);
        tick();
        checkOutput("drain_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("drain_keep_data", {24'd0, out_data}, 32'hA5);
        checkOutput("drain_keep_sel", {30'd0, out_sel}, 32'd0);

        // All lanes are valid and the consumer is always ready.
        doReset();
        applyStimulus(4'b1111, 1'b1, 8'h10, 8'h11, 8'h12, 8'h13);
        for (int i = 0; i < 5; i++) begin
            logic [1:0] expSel;
`ifdef P2_TDM_RR_EN
            expSel = 2'(i % 4);
`else
            expSel = 2'd0;
`endif
            tick();
            checkOutput($sformatf("all_valid_%0d", i), {31'd0, out_valid}, 32'd1);
            checkOutput($sformatf("all_sel_%0d", i), {30'd0, out_sel}, {30'd0, expSel});
            checkOutput($sformatf("all_data_%0d", i), {24'd0, out_data},
                        32'h10 + {30'd0, expSel});
        end

        // Backpressure: the word 0x33 must hold while all lanes request.
        doReset();
        applyStimulus(4'b0001, 1'b1, 8'h33, 8'h00, 8'h00, 8'h00);
        tick();
        checkOutput("bp_load_data", {24'd0, out_data}, 32'h33);
        applyStimulus(4'b1111, 1'b0, 8'h44, 8'h45, 8'h46, 8'h47);
        for (int i = 0; i < 5; i++) begin
            #1;
            checkOutput($sformatf("bp_in_ready_%0d", i), {28'd0, in_ready}, 32'h0);
            tick();
            checkOutput($sformatf("bp_valid_%0d", i), {31'd0, out_valid}, 32'd1);
            checkOutput($sformatf("bp_data_%0d", i), {24'd0, out_data}, 32'h33);
            checkOutput($sformatf("bp_sel_%0d", i), {30'd0, out_sel}, 32'd0);
        end

        // Lane 2 withdraws its request before it is granted. Nothing loads.
        applyStimulus(4'b0100, 1'b0, 8'h00, 8'h00, 8'h66, 8'h00);
        tick();
        applyStimulus(4'b0000, 1'b1, 8'h00, 8'h00, 8'h66, 8'h00);
        tick();
        checkOutput("withdraw_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("withdraw_data", {24'd0, out_data}, 32'h33);

        // Lanes 1 and 3 request together.
        doReset();
        applyStimulus(4'b1010, 1'b1, 8'h00, 8'h21, 8'h00, 8'h23);
        for (int i = 0; i < 4; i++) begin
            logic [1:0] expSel;
`ifdef P2_TDM_RR_EN
            expSel = (i % 2 == 0) ? 2'd1 : 2'd3;
`else
            expSel = 2'd1;
`endif
            tick();
            checkOutput($sformatf("l13_sel_%0d", i), {30'd0, out_sel}, {30'd0, expSel});
            checkOutput($sformatf("l13_data_%0d", i), {24'd0, out_data},
                        32'h20 + {30'd0, expSel});
        end

        // Reset mid-hold discards the word. Lane 2 is then granted again.
        doReset();
        applyStimulus(4'b0100, 1'b0, 8'h00, 8'h00, 8'h5C, 8'h00);
        tick();
        checkOutput("mid_rst_full", {31'd0, out_valid}, 32'd1);
        checkOutput("mid_rst_sel_pre", {30'd0, out_sel}, 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("mid_rst_sel_clr", {30'd0, out_sel}, 32'd0);
        checkOutput("mid_rst_in_ready", {28'd0, in_ready}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checkOutput("post_rst_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("post_rst_sel", {30'd0, out_sel}, 32'd2);
        checkOutput("post_rst_data", {24'd0, out_data}, 32'h5C);

        // Lane 3 alone, then lanes 3 and 0: the search wraps around to 0.
        doReset();
        applyStimulus(4'b1000, 1'b1, 8'h70, 8'h00, 8'h00, 8'h73);
        tick();
        checkOutput("wrap_sel_a", {30'd0, out_sel}, 32'd3);
        applyStimulus(4'b1001, 1'b1, 8'h70, 8'h00, 8'h00, 8'h73);
        tick();
        checkOutput("wrap_sel_b", {30'd0, out_sel}, 32'd0);
        checkOutput("wrap_data_b", {24'd0, out_data}, 32'h70);
        tick();
`ifdef P2_TDM_RR_EN
        checkOutput("wrap_sel_c", {30'd0, out_sel}, 32'd3);
`else
        checkOutput("wrap_sel_c", {30'd0, out_sel}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/p2_tdm_mux.md
P2_TDM_MUX -- requirements
Module: p2_tdm_mux

Interface
REQ-001 Parameter DW, default 8, data width of every lane and of the output.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  4  per-lane request; bit k means lane k presents data.
REQ-005 in_data0..in_data3  input  DW each  lane payloads.
REQ-006 in_ready  output  4  per-lane accept; at most one bit high per cycle.
REQ-007 out_valid  output  1  output register holds a word.
REQ-008 out_data  output  DW  selected payload.
REQ-009 out_sel  output  2  {S1,S0} lane index of out_data, the select a downstream 1-to-4 demux uses.
REQ-010 out_ready  input  1  downstream accept.

Function
REQ-011 The block SHALL be a 4-to-1 time-division multiplexer with a single-entry registered output and valid/ready handshakes on both sides.
REQ-012 FSM SHALL have two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-013 Load-enable ld = (state==EMPTY) | out_ready; grant SHALL be computed combinationally from in_valid and the arbitration pointer.
REQ-014 in_ready[k] SHALL equal grant[k] & ld; in_ready SHALL be 0 when no lane is valid.
REQ-015 A transfer on lane k (in_valid[k] & in_ready[k]) SHALL register in_datak into out_data and k into out_sel at the next edge; latency is one cycle.
REQ-016 EMPTY->FULL on any transfer; FULL->EMPTY on out_ready with no transfer; FULL stays FULL on out_ready with a transfer (back-to-back, one word per cycle, no bubble).
REQ-017 While FULL and out_ready=0, out_data and out_sel SHALL hold stable and in_ready SHALL be 0.
REQ-018 Arbitration pointer last (2 bits) SHALL update to the granted index only on a transfer; search order is last+1, last+2, last+3, last (mod 4, 3 wraps to 0).
REQ-019 in_valid deasserted by a lane before it is granted SHALL be ignored; no word is lost or duplicated.
REQ-020 out_data and out_sel SHALL hold their last values when going EMPTY (don't-care to consumer, but not cleared).
REQ-021 The only combinational path from out_ready SHALL be to in_ready.

Reset
REQ-022 rst_n low SHALL asynchronously force: state=EMPTY, out_valid=0, out_data=0, out_sel=0, last=3 (lane 0 served first).
REQ-023 in_ready SHALL be 0 while rst_n is low.
REQ-024 Reset asserted while FULL SHALL discard the held word; after release the block starts from EMPTY.

Configuration
REQ-025 Macro P2_TDM_RR_EN: defined -> round-robin per REQ-018.
REQ-026 Without P2_TDM_RR_EN -> fixed priority, lane 0 highest, lane 3 lowest; pointer logic absent; all other behaviour identical.

Verification
REQ-027 Reset, then in_valid=4'b0001, in_data0=8'hA5, out_ready=1 -> next cycle out_valid=1, out_data=A5, out_sel=2'b00.
REQ-028 RR build, in_valid=4'b1111 held, out_ready=1, data k=8'h10+k -> out_sel sequence 0,1,2,3,0 on consecutive cycles, no bubbles.
REQ-029 FULL with out_data=8'h33, out_ready=0 for 5 cycles, all lanes valid -> out_data/out_sel stable, in_ready=4'b0000 throughout.
REQ-030 Non-RR build, in_valid=4'b1010 held -> out_sel=1 every cycle; lane 3 never granted while lane 1 valid.
REQ-031 in_valid=4'b0100, out_ready=0; rst_n pulsed low mid-hold -> out_valid=0 immediately, after release lane 2 re-granted, out_sel=2'b10.
REQ-032 RR build, last=3, in_valid=4'b1000 then 4'b1001 -> grants 3 then 0 (wrap-around).
